// File: rtl/timer_pkg.sv
// Shared types and BCD helpers for the mm:ss countdown timer.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2,
        DONE    = 2'd3
    } timerState_t;

    typedef logic [7:0] bcd2_t;

    typedef struct packed {
        bcd2_t value;
        logic  borrow;
    } bcdDec_t;

    localparam logic [3:0] BCD_MAX_TENS = 4'd5;
    localparam logic [3:0] BCD_MAX_ONES = 4'd9;

    function automatic logic bcdValid(input bcd2_t v);
        return (v[7:4] <= BCD_MAX_TENS) && (v[3:0] <= BCD_MAX_ONES);
    endfunction

    // Two-digit BCD minus one; 00 wraps to 59 and raises borrow.
    function automatic bcdDec_t bcdDec(input bcd2_t v);
        bcdDec_t r;
        r.borrow = 1'b0;
        if (v[3:0] != 4'd0) begin
            r.value = {v[7:4], v[3:0] - 4'd1};
        end else if (v[7:4] != 4'd0) begin
            r.value = {v[7:4] - 4'd1, BCD_MAX_ONES};
        end else begin
            r.value  = {BCD_MAX_TENS, BCD_MAX_ONES};
            r.borrow = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Synchronizes slowClk into clk and emits a registered one-cycle tick per rising edge.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic tick
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic [SYNC_STAGES-1:0] fill_r;
    logic                   prev_r;
    logic                   armed_r;
    logic                   tick_r;

    // fill_r marks when the last sync stage holds a real sample rather than its reset value
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_r  <= {SYNC_STAGES{1'b0}};
            fill_r  <= {SYNC_STAGES{1'b0}};
            prev_r  <= 1'b0;
            armed_r <= 1'b0;
            tick_r  <= 1'b0;
        end else begin
            sync_r  <= {sync_r[SYNC_STAGES-2:0], din};
            fill_r  <= {fill_r[SYNC_STAGES-2:0], 1'b1};
            prev_r  <= sync_r[SYNC_STAGES-1];
            armed_r <= armed_r | (fill_r[SYNC_STAGES-1] & ~sync_r[SYNC_STAGES-1]);
            tick_r  <= armed_r & sync_r[SYNC_STAGES-1] & ~prev_r;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/countdown_timer.sv
// BCD mm:ss countdown timer with run/pause/done control, clocked by a slowClk-derived tick.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       slowClk,
    input  logic       load,
    input  logic [7:0] loadMin,
    input  logic [7:0] loadSec,
    input  logic       startStop,
    output logic [7:0] minutes,
    output logic [7:0] seconds,
    output logic       running,
    output logic       expired,
    output logic       expiredPulse,
    output logic       loadErr
);

    timerState_t state_r, state_nxt_s;
    bcd2_t       min_r, sec_r, min_nxt_s, sec_nxt_s;
    bcdDec_t     sec_dec_s, min_dec_s;
    logic        tick_s, load_ok_s, is_zero_s, at_one_s, dec_ok_s;
    logic        running_r, expired_r, pulse_r, err_r;
    logic        running_nxt_s, expired_nxt_s, pulse_nxt_s, err_nxt_s;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
        .clk   (clk),
        .reset (reset),
        .din   (slowClk),
        .tick  (tick_s)
    );

    assign load_ok_s = bcdValid(loadMin) && bcdValid(loadSec);
    assign sec_dec_s = bcdDec(sec_r);
    assign min_dec_s = bcdDec(min_r);
    assign is_zero_s = (min_r == 8'h00) && (sec_r == 8'h00);
    assign at_one_s  = (min_r == 8'h00) && (sec_r == 8'h01);
    assign dec_ok_s  = !(sec_dec_s.borrow && min_dec_s.borrow);

    // State, count and status registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            min_r     <= 8'h00;
            sec_r     <= 8'h00;
            running_r <= 1'b0;
            expired_r <= 1'b0;
            pulse_r   <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            min_r     <= min_nxt_s;
            sec_r     <= sec_nxt_s;
            running_r <= running_nxt_s;
            expired_r <= expired_nxt_s;
            pulse_r   <= pulse_nxt_s;
            err_r     <= err_nxt_s;
        end
    end

    // Next state and count; load outranks startStop in every state
    always_comb begin
        state_nxt_s = state_r;
        min_nxt_s   = min_r;
        sec_nxt_s   = sec_r;
        case (state_r)
            IDLE: begin
                if (load) begin
                    if (load_ok_s) begin
                        min_nxt_s = loadMin;
                        sec_nxt_s = loadSec;
                    end else begin
                        min_nxt_s = min_r;
                    end
                end else if (startStop && !is_zero_s) begin
                    state_nxt_s = RUNNING;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUNNING: begin
                if (startStop && !load) begin
                    state_nxt_s = PAUSED;
                end else if (tick_s && !is_zero_s && dec_ok_s) begin
                    sec_nxt_s = sec_dec_s.value;
                    min_nxt_s = sec_dec_s.borrow ? min_dec_s.value : min_r;
                    state_nxt_s = at_one_s ? DONE : RUNNING;
                end else begin
                    state_nxt_s = RUNNING;
                end
            end
            PAUSED: begin
                if (load) begin
                    if (load_ok_s) begin
                        min_nxt_s   = loadMin;
                        sec_nxt_s   = loadSec;
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = PAUSED;
                    end
                end else if (startStop) begin
                    state_nxt_s = RUNNING;
                end else begin
                    state_nxt_s = PAUSED;
                end
            end
            DONE: begin
                if (load && load_ok_s) begin
                    min_nxt_s   = loadMin;
                    sec_nxt_s   = loadSec;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                min_nxt_s   = 8'h00;
                sec_nxt_s   = 8'h00;
            end
        endcase
    end

    // Status values registered alongside the state they describe
    always_comb begin
        running_nxt_s = (state_nxt_s == RUNNING);
        expired_nxt_s = (state_nxt_s == DONE);
        pulse_nxt_s   = (state_r == RUNNING) && (state_nxt_s == DONE);
        err_nxt_s     = load && !load_ok_s && (state_r != RUNNING);
    end

    assign minutes      = min_r;
    assign seconds      = sec_r;
    assign running      = running_r;
    assign expired      = expired_r;
    assign expiredPulse = pulse_r;
    assign loadErr      = err_r;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed table, corner sequences and random run vs a seconds-count model.
module tb_countdown_timer;

    localparam int N = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       slowClk;
    logic       load;
    logic [7:0] loadMin;
    logic [7:0] loadSec;
    logic       startStop;
    logic [7:0] minutes;
    logic [7:0] seconds;
    logic       running;
    logic       expired;
    logic       expiredPulse;
    logic       loadErr;

    countdown_timer #(.SYNC_STAGES(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .slowClk      (slowClk),
        .load         (load),
        .loadMin      (loadMin),
        .loadSec      (loadSec),
        .startStop    (startStop),
        .minutes      (minutes),
        .seconds      (seconds),
        .running      (running),
        .expired      (expired),
        .expiredPulse (expiredPulse),
        .loadErr      (loadErr)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int pulses_seen = 0;

    // Reference model: count kept as plain total seconds
    int m_state;
    int m_cnt;
    int m_edge;
    bit m_pulse;
    bit m_err;
    bit s_hist [0:16383];

    typedef struct {
        logic       ld;
        logic [7:0] lm;
        logic [7:0] ls;
        logic       ss;
        logic [7:0] em;
        logic [7:0] es;
        logic       erun;
        logic       eexp;
        logic       epulse;
        logic       eerr;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    function automatic bit bcd_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
    endfunction

    function automatic int bcd_val(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_cnt   = 0;
        m_edge  = 0;
        m_pulse = 1'b0;
        m_err   = 1'b0;
    endtask

    // A slowClk rise first sampled at edge r updates the count at edge r+N+1
    task automatic model_edge();
        bit tick;
        bit ok;
        int lv;
        s_hist[m_edge] = slowClk;
        tick = (m_edge >= N + 2) && s_hist[m_edge - N - 1] && !s_hist[m_edge - N - 2];
        ok = bcd_ok(loadMin) && bcd_ok(loadSec);
        lv = bcd_val(loadMin) * 60 + bcd_val(loadSec);
        m_pulse = 1'b0;
        m_err   = 1'b0;
        case (m_state)
            0: begin
                if (load) begin
                    if (ok) m_cnt = lv;
                    else m_err = 1'b1;
                end else if (startStop && m_cnt != 0) m_state = 1;
            end
            1: begin
                if (startStop && !load) m_state = 2;
                else if (tick && m_cnt > 0) begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        m_state = 3;
                        m_pulse = 1'b1;
                    end
                end
            end
            2: begin
                if (load) begin
                    if (ok) begin
                        m_cnt = lv;
                        m_state = 0;
                    end else m_err = 1'b1;
                end else if (startStop) m_state = 1;
            end
            default: begin
                if (load) begin
                    if (ok) begin
                        m_cnt = lv;
                        m_state = 0;
                    end else m_err = 1'b1;
                end
            end
        endcase
        m_edge++;
    endtask

    task automatic compare_model();
        check("model_minutes", minutes, to_bcd(m_cnt / 60));
        check("model_seconds", seconds, to_bcd(m_cnt % 60));
        check("model_running", running, m_state == 1);
        check("model_expired", expired, m_state == 3);
        check("model_expiredPulse", expiredPulse, m_pulse);
        check("model_loadErr", loadErr, m_err);
    endtask

    task automatic step(input logic ld, input logic [7:0] lm, input logic [7:0] ls,
                        input logic ss, input logic sc);
        load = ld;
        loadMin = lm;
        loadSec = ls;
        startStop = ss;
        slowClk = sc;
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
        if (expiredPulse) pulses_seen++;
    endtask

    task automatic idle(input int n, input logic sc);
        repeat (n) step(1'b0, 8'h00, 8'h00, 1'b0, sc);
    endtask

    task automatic slow_pulse(input int hi, input int lo);
        idle(hi, 1'b1);
        idle(lo, 1'b0);
    endtask

    initial begin
        reset = 1'b0;
        slowClk = 1'b0;
        load = 1'b0;
        loadMin = 8'h00;
        loadSec = 8'h00;
        startStop = 1'b0;
        model_reset();
        #25;
        check("reset_minutes", minutes, 8'h00);
        check("reset_seconds", seconds, 8'h00);
        check("reset_running", running, 1'b0);
        check("reset_expired", expired, 1'b0);
        check("reset_pulse", expiredPulse, 1'b0);
        check("reset_loadErr", loadErr, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // ld lm ls ss | minutes seconds running expired pulse err
        tbl.push_back('{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 8'h12, 8'h34, 1'b0, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 8'h00, 8'h60, 1'b0, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 8'h00, 8'h1A, 1'b0, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 8'h60, 8'h00, 1'b0, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 8'h00, 8'h05, 1'b1, 8'h00, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 8'h0B, 8'h00, 1'b1, 8'h00, 8'h05, 1'b0, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 8'h05, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 8'h00, 8'h09, 1'b0, 8'h00, 8'h05, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 8'h00, 8'h09, 1'b1, 8'h00, 8'h05, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 8'h05, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 8'h00, 8'hA0, 1'b0, 8'h00, 8'h05, 1'b0, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 8'h00, 8'h07, 1'b0, 8'h00, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 8'h00, 8'h03, 1'b0, 8'h00, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0});

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].ld, tbl[i].lm, tbl[i].ls, tbl[i].ss, 1'b0);
            check($sformatf("tbl%0d_minutes", i), minutes, tbl[i].em);
            check($sformatf("tbl%0d_seconds", i), seconds, tbl[i].es);
            check($sformatf("tbl%0d_running", i), running, tbl[i].erun);
            check($sformatf("tbl%0d_expired", i), expired, tbl[i].eexp);
            check($sformatf("tbl%0d_pulse", i), expiredPulse, tbl[i].epulse);
            check($sformatf("tbl%0d_loadErr", i), loadErr, tbl[i].eerr);
        end

        // 00:03 countdown with a surplus fourth tick
        idle(4, 1'b0);
        pulses_seen = 0;
        step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        repeat (4) slow_pulse(4, 4);
        idle(N + 2, 1'b0);
        check("done_count", {minutes, seconds}, 16'h0000);
        check("done_expired", expired, 1'b1);
        check("done_pulse_count", pulses_seen, 1);
        step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        check("done_ss_ignored", expired, 1'b1);

        // Minute and ten-minute borrows
        step(1'b1, 8'h01, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        slow_pulse(4, 4);
        idle(N + 2, 1'b0);
        check("borrow_0059", {minutes, seconds}, 16'h0059);
        step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h10, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        slow_pulse(4, 4);
        idle(N + 2, 1'b0);
        check("borrow_0959", {minutes, seconds}, 16'h0959);

        // startStop coincident with tick at 00:10
        step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h00, 8'h10, 1'b0, 1'b0);
        step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        idle(4, 1'b0);
        idle(N + 1, 1'b1);
        step(1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
        check("coinc_count", {minutes, seconds}, 16'h0010);
        check("coinc_paused", running, 1'b0);
        idle(4, 1'b0);
        repeat (3) slow_pulse(4, 4);
        idle(N + 2, 1'b0);
        check("paused_count", {minutes, seconds}, 16'h0010);
        step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        check("resume_running", running, 1'b1);

        // Reset mid-run at 05:30
        step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h05, 8'h30, 1'b0, 1'b0);
        step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        check("pre_reset_running", running, 1'b1);
        slowClk = 1'b1;
        reset = 1'b0;
        #2;
        check("async_minutes", minutes, 8'h00);
        check("async_seconds", seconds, 8'h00);
        check("async_running", running, 1'b0);
        check("async_expired", expired, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        step(1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
        check("zero_start_ignored", running, 1'b0);

        // slowClk high across reset release must not tick
        step(1'b1, 8'h00, 8'h05, 1'b0, 1'b1);
        step(1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
        idle(8, 1'b1);
        check("no_tick_high_release", {minutes, seconds}, 16'h0005);
        idle(4, 1'b0);
        slow_pulse(4, 4);
        idle(N + 2, 1'b0);
        check("tick_after_fall", {minutes, seconds}, 16'h0004);

        // Random traffic against the model
        begin
            int phase_left;
            logic lvl;
            logic ld, ss;
            logic [7:0] lm, ls;
            int r;
            phase_left = 6;
            lvl = 1'b0;
            for (int c = 0; c < 4000; c++) begin
                if (phase_left == 0) begin
                    lvl = ~lvl;
                    phase_left = $urandom_range(3, 10);
                end
                phase_left--;
                ld = ($urandom_range(0, 29) == 0);
                ss = ($urandom_range(0, 19) == 0);
                r = $urandom_range(0, 9);
                if (r < 6) lm = 8'h00;
                else if (r < 8) lm = 8'h01;
                else lm = 8'($urandom);
                r = $urandom_range(0, 9);
                if (r < 7) ls = to_bcd($urandom_range(0, 20));
                else ls = 8'($urandom);
                step(ld, lm, ls, ss, lvl);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
